// File: rtl/alu.sv
// Single-cycle 32-bit RV32I integer ALU.
//
// Computes one of 16 operations on a and b, selected by ctrl, and drives the
// result combinationally. A registered copy of the result and zero flag is
// kept for pipelined consumers.
//
// Ports:
//   clk    - clock; o_q/zero_q update on its rising edge
//   rst    - synchronous active-high reset of o_q/zero_q only
//   a      - operand A, also the shift source
//   b      - operand B; b[4:0] is the shift amount
//   ctrl   - operation select
//   o      - combinational result
//   zero   - combinational, high when o == 0
//   o_q    - o registered on clk
//   zero_q - zero registered on clk
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  ctrl,
    output logic [31:0] o,
    output logic        zero,
    output logic [31:0] o_q,
    output logic        zero_q
);

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpSub   = 4'd1,
        OpSll   = 4'd2,
        OpSlt   = 4'd3,
        OpSltu  = 4'd4,
        OpXor   = 4'd5,
        OpSrl   = 4'd6,
        OpSra   = 4'd7,
        OpOr    = 4'd8,
        OpAnd   = 4'd9,
        OpPassB = 4'd10,
        OpSge   = 4'd11,
        OpSgeu  = 4'd12,
        OpSeq   = 4'd13,
        OpSne   = 4'd14,
        OpPassA = 4'd15
    } alu_op_e;

    alu_op_e     op;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic        eq;
    logic [31:0] o_d;
    logic        zero_d;

    assign op    = alu_op_e'(ctrl);
    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;

    always_comb begin
        o = 32'h0;
        unique case (op)
            OpAdd:   o = a + b;
            OpSub:   o = a - b;
            OpSll:   o = a << shamt;
            OpSlt:   o = {31'b0, lt_s};
            OpSltu:  o = {31'b0, lt_u};
            OpXor:   o = a ^ b;
            OpSrl:   o = a >> shamt;
            OpSra:   o = $unsigned($signed(a) >>> shamt);
            OpOr:    o = a | b;
            OpAnd:   o = a & b;
            OpPassB: o = b;
            OpSge:   o = {31'b0, ~lt_s};
            OpSgeu:  o = {31'b0, ~lt_u};
            OpSeq:   o = {31'b0, eq};
            OpSne:   o = {31'b0, ~eq};
            OpPassA: o = a;
            default: o = 32'h0;
        endcase
    end

    assign zero = (o == 32'h0);

    // Reset takes priority over capture; o/zero themselves are untouched.
    always_comb begin
        o_d    = o;
        zero_d = zero;
        if (rst) begin
            o_d    = 32'h0;
            zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        o_q    <= o_d;
        zero_q <= zero_d;
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: combinational result checked against a
// reference model, registered result checked through a scoreboard queue.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] o;
    logic        zero;
    logic [31:0] o_q;
    logic        zero_q;

    int checks;
    int errors;

    logic [32:0] exp_q[$];

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .ctrl   (ctrl),
        .o      (o),
        .zero   (zero),
        .o_q    (o_q),
        .zero_q (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                            input logic [3:0] c);
        logic signed [31:0] xs;
        logic signed [31:0] ys;
        int unsigned        sh;
        logic [31:0]        r;
        xs = x;
        ys = y;
        sh = y % 32;
        case (c)
            4'd0:  r = x + y;
            4'd1:  r = x + ~y + 32'd1;
            4'd2:  r = x << sh;
            4'd3:  r = (xs < ys) ? 32'd1 : 32'd0;
            4'd4:  r = (x < y) ? 32'd1 : 32'd0;
            4'd5:  r = x ^ y;
            4'd6:  r = x >> sh;
            4'd7:  r = xs >>> sh;
            4'd8:  r = x | y;
            4'd9:  r = x & y;
            4'd10: r = y;
            4'd11: r = (xs >= ys) ? 32'd1 : 32'd0;
            4'd12: r = (x >= y) ? 32'd1 : 32'd0;
            4'd13: r = (x == y) ? 32'd1 : 32'd0;
            4'd14: r = (x != y) ? 32'd1 : 32'd0;
            default: r = x;
        endcase
        return r;
    endfunction

    // Pop the oldest expected registered value and compare with o_q/zero_q.
    task automatic check_reg(input string tag);
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 33'd0, 33'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {zero_q, o_q}, e);
        end
    endtask

    // Drive one operation; check o/zero against the model (or a fixed value when
    // exp_o is given) and the registered copy one edge later.
    task automatic apply(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] c, input bit use_fixed, input logic [31:0] fixed);
        logic [31:0] m;
        @(negedge clk);
        a    = x;
        b    = y;
        ctrl = c;
        #1;
        m = use_fixed ? fixed : ref_alu(x, y, c);
        check({tag, "_o"}, {1'b0, o}, {1'b0, m});
        check({tag, "_zero"}, {32'd0, zero}, {32'd0, m == 32'h0});
        exp_q.push_back({m == 32'h0, m});
        @(posedge clk);
        #1;
        check_reg({tag, "_reg"});
    endtask

    logic [31:0] pa[9];
    logic [31:0] pb[9];

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        a      = 32'd0;
        b      = 32'd0;
        ctrl   = 4'd0;

        // Reset state
        @(posedge clk);
        #1;
        check("reset_o_q", {zero_q, o_q}, 33'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed values from hand-derived results
        apply("add",       32'd1234567890, 32'd876543021, 4'd0, 1, 32'd2111110911);
        apply("sub",       32'd1234567890, 32'd876543021, 4'd1, 1, 32'd358024869);
        apply("add_wrap",  32'd2345678901, 32'd3456789012, 4'd0, 1, 32'd1507500617);
        apply("slt",       -32'sd10, 32'd10, 4'd3,  1, 32'd1);
        apply("sltu",      -32'sd10, 32'd10, 4'd4,  1, 32'd0);
        apply("sge",       -32'sd10, 32'd10, 4'd11, 1, 32'd0);
        apply("sgeu",      -32'sd10, 32'd10, 4'd12, 1, 32'd1);
        apply("slt_neg",   -32'sd60, -32'sd50, 4'd3, 1, 32'd1);
        apply("sll",       32'd30, 32'd40, 4'd2, 1, 32'd7680);
        apply("srl",       32'd50, 32'd40, 4'd6, 1, 32'd0);
        apply("sra",       -32'sd60, -32'sd50, 4'd7, 1, 32'hFFFF_FFFF);
        apply("srl_neg",   -32'sd60, -32'sd50, 4'd6, 1, 32'h0003_FFFF);
        apply("add_zero",  32'd20, -32'sd20, 4'd0, 1, 32'd0);
        apply("shift0",    32'hDEAD_BEEF, 32'hFFFF_FFE0, 4'd7, 1, 32'hDEAD_BEEF);

        // Register path with reset overriding capture
        apply("rp_sub",    32'd50, 32'd40, 4'd1, 1, 32'd10);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(33'd0);
        @(posedge clk);
        #1;
        check_reg("rp_rst");
        check("rp_rst_o", {zero, o}, {1'b0, 32'd10});
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({1'b0, 32'd10});
        @(posedge clk);
        #1;
        check_reg("rp_release");

        // Sweep every opcode over the operand pairs
        pa = '{32'd0, 32'd1234567890, 32'd2345678901, 32'd30, 32'd50,
               -32'sd10, 32'd20, -32'sd60, -32'sd60};
        pb = '{32'd0, 32'd876543021, 32'd3456789012, 32'd40, 32'd40,
               32'd10, -32'sd20, -32'sd50, -32'sd70};
        for (int p = 0; p < 9; p++) begin
            for (int c = 0; c < 16; c++) begin
                apply($sformatf("sweep_p%0d_c%0d", p, c), pa[p], pb[p], 4'(c), 0, 32'd0);
            end
        end

        // Random operands
        for (int i = 0; i < 64; i++) begin
            apply($sformatf("rand%0d", i), $urandom, $urandom, 4'($urandom_range(0, 15)),
                  0, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
